// File: rtl/bullet_pkg.sv
// Shared constants, colour codes and the lane x helper for the bullet pool generator.
package bullet_pkg;

    localparam logic [2:0] COLOR_BULLET  = 3'b001;
    localparam logic [2:0] COLOR_OFF     = 3'b111;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    // Lane x is computed in 8-bit arithmetic; callers keep the result below SCREEN_WIDTH.
    function automatic logic [X_W-1:0] lane_x(
        input logic [X_W-1:0] x0,
        input logic [X_W-1:0] pitch,
        input logic [X_W-1:0] lane
    );
        lane_x = x0 + lane * pitch;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active/x/y/colour registers with clear, load and move controls.
// retire is combinational so the dodge counter updates on the same edge the slot goes inactive.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int             STEP    = 1,
    parameter int             Y_MAX   = 119,
    parameter logic [X_W-1:0] X_RESET = 8'd61
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           clear,
    input  logic           load,
    input  logic           move,
    input  logic [X_W-1:0] load_x,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     color,
    output logic           retire
);

    logic           active_next;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic [Y_W:0]   y_step;

    // One extra bit so a bullet near the bottom cannot wrap back to the top.
    assign y_step = {1'b0, y} + (Y_W+1)'(STEP);
    assign retire = move && active && (y_step > (Y_W+1)'(Y_MAX));

    always_comb begin
        active_next = active;
        x_next      = x;
        y_next      = y;
        if (clear) begin
            active_next = 1'b0;
            y_next      = '0;
        end else if (load) begin
            active_next = 1'b1;
            x_next      = load_x;
            y_next      = '0;
        end else if (move && active) begin
            if (retire) begin
                active_next = 1'b0;
            end else begin
                y_next = y_step[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            x      <= X_RESET;
            y      <= '0;
            color  <= COLOR_OFF;
        end else begin
            active <= active_next;
            x      <= x_next;
            y      <= y_next;
            color  <= active_next ? COLOR_BULLET : COLOR_OFF;
        end
    end

endmodule

// File: rtl/bullet_pool_generator.sv
// Pool of falling bullets spawned into LFSR-chosen lanes and moved on a shared tick.
// Optional SPEED_RAMP_EN shortens the move period every 8 dodges.
module bullet_pool_generator
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS   = 4,
    parameter int NUM_LANES     = 4,
    parameter int LANE_X0       = 61,
    parameter int LANE_PITCH    = 10,
    parameter int SCREEN_HEIGHT = 120,
    parameter int SPAWN_PERIOD  = 25_000_000,
    parameter int MOVE_PERIOD   = 5_000_000,
    parameter int STEP          = 1,
    parameter int CNT_W         = 25
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         player_collision,
    input  logic [$clog2(NUM_LANES)-1:0] rand_in,
    output logic [8*NUM_BULLETS-1:0]     bullet_x,
    output logic [7*NUM_BULLETS-1:0]     bullet_y,
    output logic [NUM_BULLETS-1:0]       bullet_active,
    output logic [3*NUM_BULLETS-1:0]     bullet_color,
    output logic                         spawn_drop,
    output logic [7:0]                   dodged_count
);

    logic                   run;
    logic [CNT_W-1:0]       spawn_cnt;
    logic [CNT_W-1:0]       move_cnt;
    logic [CNT_W-1:0]       move_period;
    logic                   spawn_tick;
    logic                   move_tick;
    logic                   no_free;
    logic                   taken;
    logic [NUM_BULLETS-1:0] load_vec;
    logic [NUM_BULLETS-1:0] retire_vec;
    logic [4:0]             retire_count;
    logic [8:0]             dodge_sum;
    logic [7:0]             dodge_next;
    logic [X_W-1:0]         spawn_x;

    assign run        = enable && !player_collision;
    assign spawn_tick = run && (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1));
    assign move_tick  = run && (move_cnt >= move_period - CNT_W'(1));
    assign no_free    = spawn_tick && (&bullet_active);
    assign spawn_x    = lane_x(X_W'(LANE_X0), X_W'(LANE_PITCH), X_W'(rand_in));

    // Lowest free slot wins; occupancy is taken from before the edge, so a slot
    // retiring on this same tick cannot be reused until the next spawn.
    always_comb begin
        load_vec = '0;
        taken    = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (spawn_tick && !taken && !bullet_active[i]) begin
                load_vec[i] = 1'b1;
                taken       = 1'b1;
            end
        end
    end

    always_comb begin
        retire_count = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            retire_count = retire_count + 5'(retire_vec[i]);
        end
    end

    assign dodge_sum  = {1'b0, dodged_count} + 9'(retire_count);
    assign dodge_next = dodge_sum[8] ? 8'hFF : dodge_sum[7:0];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            spawn_cnt    <= '0;
            move_cnt     <= '0;
            spawn_drop   <= 1'b0;
            dodged_count <= '0;
        end else begin
            dodged_count <= dodge_next;
            if (!run) begin
                spawn_cnt  <= '0;
                move_cnt   <= '0;
                spawn_drop <= 1'b0;
            end else begin
                spawn_cnt  <= spawn_tick ? '0 : spawn_cnt + CNT_W'(1);
                move_cnt   <= move_tick ? '0 : move_cnt + CNT_W'(1);
                spawn_drop <= no_free;
            end
        end
    end

`ifdef SPEED_RAMP_EN
    localparam logic [CNT_W-1:0] RAMP_STEP  = CNT_W'(MOVE_PERIOD / 8);
    localparam logic [CNT_W-1:0] RAMP_FLOOR = CNT_W'(MOVE_PERIOD / 4);

    // A change in the upper five bits means the count just crossed a multiple of 8.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            move_period <= CNT_W'(MOVE_PERIOD);
        end else if (!run) begin
            move_period <= CNT_W'(MOVE_PERIOD);
        end else if (dodge_next[7:3] != dodged_count[7:3]) begin
            move_period <= (move_period >= RAMP_FLOOR + RAMP_STEP) ?
                           move_period - RAMP_STEP : RAMP_FLOOR;
        end
    end
`else
    assign move_period = CNT_W'(MOVE_PERIOD);
`endif

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(
            .STEP    (STEP),
            .Y_MAX   (SCREEN_HEIGHT - 1),
            .X_RESET (X_W'(LANE_X0))
        ) u_slot (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .clear    (!run),
            .load     (load_vec[i]),
            .move     (move_tick),
            .load_x   (spawn_x),
            .active   (bullet_active[i]),
            .x        (bullet_x[8*i +: 8]),
            .y        (bullet_y[7*i +: 7]),
            .color    (bullet_color[3*i +: 3]),
            .retire   (retire_vec[i])
        );
    end

endmodule

// File: doc/bullet_pool_generator.md
Name: bullet_pool_generator

Overview:
Parametrised multi-bullet successor to the single-bullet generator in the dodge-phase game logic. Manages a pool of NUM_BULLETS independent falling bullets. Spawns them into NUM_LANES evenly spaced lanes chosen by an external LFSR value, and moves all active bullets down on a shared move tick. Outputs packed position, active and colour vectors to the VGA renderer and the collision checker, plus a dodge counter and a drop flag.

Parameters:
NUM_BULLETS, 4, pool size (1..16)
NUM_LANES, 4, number of spawn lanes (power of 2, 2..16)
LANE_X0, 61, x of lane 0
LANE_PITCH, 10, x spacing between lanes
SCREEN_HEIGHT, 120, rows; a bullet retires past SCREEN_HEIGHT-1
SPAWN_PERIOD, 25_000_000, clocks between spawn attempts
MOVE_PERIOD, 5_000_000, clocks between move ticks
STEP, 1, pixels moved per move tick
CNT_W, 25, width of the spawn and move counters (must hold both periods)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  game phase running
player_collision  in  1  player hit; clears pool
rand_in  in  $clog2(NUM_LANES)  LFSR value used as lane index
bullet_x  out  8*NUM_BULLETS  packed x, slot i at [8i+7:8i]
bullet_y  out  7*NUM_BULLETS  packed y
bullet_active  out  NUM_BULLETS  slot active flags
bullet_color  out  3*NUM_BULLETS  3'b001 active, 3'b111 inactive
spawn_drop  out  1  one-cycle pulse: spawn tick found no free slot
dodged_count  out  8  bullets retired at the bottom, saturating

Behaviour:
- Reset (async, resetn=0): all slots inactive, x=LANE_X0, y=0, colour 3'b111; counters=0; spawn_drop=0; dodged_count=0.
- Run condition: enable=1 and player_collision=0. Otherwise, on each clock: all slots inactive, y=0, both counters=0, spawn_drop=0. x and dodged_count hold.
- Spawn counter counts 0..SPAWN_PERIOD-1. The cycle it equals SPAWN_PERIOD-1 is the spawn tick; the counter wraps to 0 on that cycle.
- On a spawn tick, the lowest-index inactive slot is loaded: active=1, y=0, x=LANE_X0+rand_in*LANE_PITCH. rand_in is sampled on that same cycle. x arithmetic is 8-bit, and the parameter set must keep x<160.
- If no slot is free on a spawn tick, spawn_drop pulses for exactly one cycle and no slot changes.
- Move counter is free-running while the run condition holds, independent of slot state. Counts 0..MOVE_PERIOD-1; the terminal cycle is the move tick.
- On a move tick, every slot that was active before this edge is processed:
  - if y+STEP <= SCREEN_HEIGHT-1: y advances by STEP.
  - otherwise: the slot goes inactive and dodged_count increments, saturating at 255.
  - Compute y+STEP at 8 bits to avoid 7-bit wrap.
- Multiple slots retiring on the same tick each add 1 (popcount), still saturating.
- Simultaneous spawn tick and move tick:
  - The newly spawned slot is not moved; it shows y=0 after the edge.
  - A slot freed by that same move tick is not eligible for allocation until the next edge.
- Colour is registered together with active, so the two change on the same edge.
- All outputs are registered. Latency from tick to output is 1 clock.

Optional Feature:
SPEED_RAMP_EN
- Defined: the effective move period starts at MOVE_PERIOD. Every time dodged_count crosses a multiple of 8, the period is reduced by MOVE_PERIOD/8, floored at MOVE_PERIOD/4. The period resets to MOVE_PERIOD on reset or when the run condition is lost.
- Undefined: the move period is the fixed MOVE_PERIOD and no ramp logic is synthesised.

Decomposition:
- Package bullet_pkg holds:
  - COLOR_BULLET=3'b001 and COLOR_OFF=3'b111
  - SCREEN_WIDTH=160 and SCREEN_HEIGHT=120
  - X_W=8 and Y_W=7
  - the lane-x helper function
- One sub-module, bullet_slot: a single slot's active/x/y/colour registers, with load, move and clear inputs and a retire pulse output.
  - Instantiated NUM_BULLETS times through generate.
  - The top level keeps the counters, the priority free-slot encoder and the dodge popcount.

Test Plan:
- Small periods, bench-overridden:
  - SPAWN_PERIOD=8, MOVE_PERIOD=2, SCREEN_HEIGHT=10, NUM_BULLETS=2.
  - Release reset with rand_in=3.
  - Required: slot0 active at x=91, y=0 on the cycle after the first spawn tick; y increments every 2 clocks; slot1 fills on the next spawn tick.
- Pool full:
  - NUM_BULLETS=2, SPAWN_PERIOD=4, MOVE_PERIOD=100.
  - Required: third spawn tick gives spawn_drop=1 for one cycle; slots are unchanged.
- Retire:
  - One bullet reaches y=9 with SCREEN_HEIGHT=10.
  - Required: the next move tick deactivates it, dodged_count becomes 1, colour becomes 3'b111 on the same edge.
- Coincident ticks:
  - SPAWN_PERIOD=MOVE_PERIOD=4, pool full, slot0 at y=9.
  - Required: slot0 retires and no new spawn happens that edge, spawn_drop=1; the next spawn tick loads slot0.
- Abort:
  - Assert player_collision with 2 bullets active mid-flight.
  - Required: next edge all inactive and y=0, dodged_count unchanged. Then assert resetn=0 asynchronously mid-clock: all outputs at reset values immediately.
- SPEED_RAMP_EN, MOVE_PERIOD=16:
  - After 8 dodges the move tick interval is 14 clocks; the floor of 4 is reached and held.
